// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-master arbiter with burst cap for a single-port RAM
module ram_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_data_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_data_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_data_o,
    output logic          ram_we_o,
    input  logic [DW-1:0] ram_data_i
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]    rvalid_q, rvalid_d;

    logic   cur_owner;
    logic   own_req;
    logic   oth_req;
    state_t oth_state;

    assign cur_owner = (state_q == OWN1);
    assign own_req   = cur_owner ? m1_req_i : m0_req_i;
    assign oth_req   = cur_owner ? m0_req_i : m1_req_i;
    assign oth_state = cur_owner ? OWN0 : OWN1;

    // Next owner: tie from idle goes to whoever did not own last; an owner
    // keeps the RAM until it stops requesting or hits the burst cap while the
    // other master is waiting.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                if (m0_req_i && m1_req_i) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (m0_req_i) begin
                    state_d = OWN0;
                end else if (m1_req_i) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (own_req) begin
                    if (burst_cnt_q < CAP) begin
                        burst_cnt_d = burst_cnt_q + CW'(1);
                    end else begin
                        burst_cnt_d = '0;
                        if (oth_req) begin
                            state_d      = oth_state;
                            last_owner_d = cur_owner;
                        end
                    end
                end else begin
                    burst_cnt_d  = '0;
                    last_owner_d = cur_owner;
                    state_d      = oth_req ? oth_state : IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // RAM port is driven by the current owner; idle parks everything at zero.
    always_comb begin
        ram_addr_o = '0;
        ram_data_o = '0;
        case (state_q)
            OWN0: begin
                ram_addr_o = m0_addr_i;
                ram_data_o = m0_data_i;
            end
            OWN1: begin
                ram_addr_o = m1_addr_i;
                ram_data_o = m1_data_i;
            end
            default: begin
                ram_addr_o = '0;
                ram_data_o = '0;
            end
        endcase
    end

    assign m0_gnt_o = (state_q == OWN0) && m0_req_i;
    assign m1_gnt_o = (state_q == OWN1) && m1_req_i;
    assign ram_we_o = (m0_gnt_o && m0_we_i) || (m1_gnt_o && m1_we_i);

    assign rvalid_d    = {m1_gnt_o && !m1_we_i, m0_gnt_o && !m0_we_i};
    assign m0_rvalid_o = rvalid_q[0];
    assign m1_rvalid_o = rvalid_q[1];
    assign m0_rdata_o  = ram_data_i;
    assign m1_rdata_o  = ram_data_i;

    // State, ownership history, burst counter and read-return flags.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            rvalid_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            rvalid_q     <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed checks of ram_arbiter against a behavioural model
module tb_ram_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, addr1;
    logic [7:0]  data0, data1;
    logic        gnt0, gnt1, rv0, rv1;
    logic [7:0]  rd0, rd1;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_we;

    ram_arbiter #(.AW(16), .DW(8), .MAX_BURST(MAXB)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(req0), .m0_we_i(we0), .m0_addr_i(addr0), .m0_data_i(data0),
        .m0_gnt_o(gnt0), .m0_rvalid_o(rv0), .m0_rdata_o(rd0),
        .m1_req_i(req1), .m1_we_i(we1), .m1_addr_i(addr1), .m1_data_i(data1),
        .m1_gnt_o(gnt1), .m1_rvalid_o(rv1), .m1_rdata_o(rd1),
        .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_we_o(ram_we),
        .ram_data_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // Physical RAM seen by the DUT.
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (ram_we === 1'b1) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Behavioural model: owner (-1 none), master that owned last, run length
    // of the current tenure, scoreboard memory and pending read returns.
    logic [7:0] mmem [0:65535];
    int         own, last, run;
    bit         mvalid;
    bit         pend_v [2];
    logic [7:0] pend_d [2];

    int n_cmp = 0;
    int n_err = 0;

    logic        obs_g0, obs_g1, obs_rv0, obs_rv1, obs_we;
    logic [7:0]  obs_rd0, obs_rd1, obs_wd;
    logic [15:0] obs_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        bit eg0, eg1, r0, r1;
        @(negedge clk);
        obs_g0 = gnt0; obs_g1 = gnt1; obs_rv0 = rv0; obs_rv1 = rv1;
        obs_rd0 = rd0; obs_rd1 = rd1; obs_we = ram_we; obs_addr = ram_addr; obs_wd = ram_wdata;
        if (mvalid) begin
            eg0 = (own == 0) && req0;
            eg1 = (own == 1) && req1;
            chk("gnt0", obs_g0, eg0);
            chk("gnt1", obs_g1, eg1);
            chk("gnt_excl", obs_g0 & obs_g1, 0);
            chk("rvalid0", obs_rv0, pend_v[0]);
            chk("rvalid1", obs_rv1, pend_v[1]);
            if (pend_v[0]) chk("rdata0", obs_rd0, pend_d[0]);
            if (pend_v[1]) chk("rdata1", obs_rd1, pend_d[1]);
            chk("ram_we", obs_we, (eg0 && we0) || (eg1 && we1));
            if (eg0) chk("ram_addr0", obs_addr, addr0);
            if (eg1) chk("ram_addr1", obs_addr, addr1);
            if (eg0 && we0) chk("ram_wdata0", obs_wd, data0);
            if (eg1 && we1) chk("ram_wdata1", obs_wd, data1);
            if (own < 0) begin
                chk("idle_addr", obs_addr, 0);
                chk("idle_wdata", obs_wd, 0);
            end
        end
        @(posedge clk);
        if (!rst) begin
            own = -1; last = 1; run = 0;
            pend_v[0] = 0; pend_v[1] = 0;
            mvalid = 1;
        end else if (mvalid) begin
            eg0 = (own == 0) && req0;
            eg1 = (own == 1) && req1;
            pend_v[0] = eg0 && !we0; pend_d[0] = mmem[addr0];
            pend_v[1] = eg1 && !we1; pend_d[1] = mmem[addr1];
            if (eg0 && we0) mmem[addr0] = data0;
            if (eg1 && we1) mmem[addr1] = data1;
            if (own < 0) begin
                if (req0 && req1) own = (last == 1) ? 0 : 1;
                else if (req0) own = 0;
                else if (req1) own = 1;
            end else begin
                r0 = (own == 0) ? req0 : req1;
                r1 = (own == 0) ? req1 : req0;
                if (r0) begin
                    run++;
                    if (run == MAXB) begin
                        run = 0;
                        if (r1) begin last = own; own = 1 - own; end
                    end
                end else begin
                    run = 0;
                    last = own;
                    own = r1 ? 1 - own : -1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        int pat [10];
        pat = '{0, 1, 1, 1, 1, 2, 2, 2, 2, 1};
        mvalid = 0; own = -1; last = 1; run = 0;
        pend_v[0] = 0; pend_v[1] = 0;
        for (int i = 0; i < 65536; i++) begin
            ram[i]  = 8'(i) ^ 8'h5A;
            mmem[i] = 8'(i) ^ 8'h5A;
        end
        ram[16'h1234]  = 8'hA5;
        mmem[16'h1234] = 8'hA5;
        rst = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;

        // Reset state.
        do_reset();
        step();
        chk("rst_gnt", {obs_g1, obs_g0}, 0);
        chk("rst_rvalid", {obs_rv1, obs_rv0}, 0);
        chk("rst_we", obs_we, 0);
        chk("rst_addr", obs_addr, 0);

        // m0 read of 0x1234.
        req0 = 1; we0 = 0; addr0 = 16'h1234;
        step(); chk("t1_gnt_t0", obs_g0, 0);
        step(); chk("t1_gnt_t1", obs_g0, 1); chk("t1_addr", obs_addr, 16'h1234); chk("t1_we", obs_we, 0);
        req0 = 0;
        step(); chk("t1_rvalid", obs_rv0, 1); chk("t1_rdata", obs_rd0, 8'hA5); chk("t1_we2", obs_we, 0);

        // m1 writes 0x3C to 0x00FF, then m0 reads it back.
        req1 = 1; we1 = 1; addr1 = 16'h00FF; data1 = 8'h3C;
        step();
        step(); chk("t3_wgnt", obs_g1, 1); chk("t3_we", obs_we, 1);
        req1 = 0; req0 = 1; we0 = 0; addr0 = 16'h00FF;
        step(); chk("t3_gap", obs_g0, 0);
        step(); chk("t3_rgnt", obs_g0, 1);
        req0 = 0;
        step(); chk("t3_rvalid", obs_rv0, 1); chk("t3_rdata", obs_rd0, 8'h3C);

        // Both request from reset: 4 x m0, 4 x m1, then m0.
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h0010; addr1 = 16'h0020;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t2_gnt%0d", i), {obs_g1, obs_g0}, pat[i]);
        end

        // Owner drops after 2 accesses while m1 waits.
        do_reset();
        req0 = 1; req1 = 1;
        step(); step(); step();
        chk("t4_g0", {obs_g1, obs_g0}, 1);
        req0 = 0;
        step(); chk("t4_drop", {obs_g1, obs_g0}, 0);
        step(); chk("t4_handover", {obs_g1, obs_g0}, 2);
        req1 = 0;

        // Reset mid-burst with a read pending.
        do_reset();
        req0 = 1; we0 = 0; addr0 = 16'h1234;
        step(); step();
        rst = 0;
        step(); chk("t5_rv_before", obs_rv0, 1);
        rst = 1; req1 = 1; we1 = 0;
        step();
        chk("t5_gnt", {obs_g1, obs_g0}, 0);
        chk("t5_rvalid", {obs_rv1, obs_rv0}, 0);
        chk("t5_we", obs_we, 0);
        chk("t5_addr", obs_addr, 0);
        step(); chk("t5_tie", {obs_g1, obs_g0}, 1);

        // m0 alone: continuous grants across the burst cap.
        do_reset();
        req0 = 1; we0 = 0;
        step();
        for (int i = 0; i < 10; i++) begin
            addr0 = 16'(i);
            step();
            chk($sformatf("t6_gnt%0d", i), obs_g0, 1);
        end

        // Randomized traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 199) != 0);
            if (!req0 || obs_g0) begin
                req0 = ($urandom_range(0, 2) != 0); we0 = 1'($urandom);
                addr0 = {12'h004, 4'($urandom)}; data0 = 8'($urandom);
            end
            if (!req1 || obs_g1) begin
                req1 = ($urandom_range(0, 2) != 0); we1 = 1'($urandom);
                addr1 = {12'h004, 4'($urandom)}; data1 = 8'($urandom);
            end
        end
        rst = 1; req0 = 0; req1 = 0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
